count_checker: RTL and testbench

Downstream consumer of the 4-bit ripple/up counter output. It samples the counter's Q bus every clock and verifies that the count sequence is legal. It emits a one-cycle pulse on each 15→0 wrap and keeps a saturating wrap tally. Upstream clears are reported as resync events; any other illegal jump is flagged as a sequence error.

---
 rtl/count_checker.sv | 112 +++++++++++
 tb/tb_count_checker.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/count_checker.sv
// Sequence monitor for an upstream up-counter: locks onto a legal count stream,
// pulses on each max->0 wrap, reports upstream clears and tallies illegal jumps.
module count_checker #(
  parameter int WIDTH  = 4,
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 4,
  parameter int LOCK_N = 2
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [WIDTH-1:0]  q_in,
  input  logic              enable,
  output logic              locked,
  output logic              wrap,
  output logic              rsync,
  output logic [WRAP_W-1:0] wraps,
  output logic              err,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam int GOOD_W = $clog2(LOCK_N + 1);
  localparam logic [GOOD_W-1:0] LOCK_CNT = GOOD_W'(LOCK_N);
  localparam logic [WIDTH-1:0]  MAX_Q    = '1;

  typedef enum logic {SEEK, TRACK} state_t;

  state_t              state, state_n;
  logic [WIDTH-1:0]    prev;
  logic                pv;
  logic [GOOD_W-1:0]   good, good_n;
  logic                wrap_n, rsync_n, err_n;
  logic [WRAP_W-1:0]   wraps_n;
  logic [ERR_W-1:0]    err_cnt_n;
  logic [WIDTH-1:0]    expected;
  logic                legal, clr_evt, bad;

  assign locked = (state == TRACK);

  // Classify the sampled value against what the counter should show now.
  // A step back to zero that is not a legal wrap is treated as an upstream clear.
  always_comb begin
    expected = enable ? prev + WIDTH'(1) : prev;
    legal    = pv && (q_in == expected);
    clr_evt  = pv && !legal && (q_in == '0);
    bad      = pv && !legal && (q_in != '0);
  end

  always_comb begin
    state_n   = state;
    good_n    = good;
    wrap_n    = 1'b0;
    rsync_n   = 1'b0;
    wraps_n   = wraps;
    err_n     = err;
    err_cnt_n = err_cnt;
    case (state)
      SEEK: begin
        if (legal && enable) begin
          if (good + GOOD_W'(1) == LOCK_CNT) begin
            state_n = TRACK;
            good_n  = '0;
          end else begin
            good_n = good + GOOD_W'(1);
          end
        end else if (clr_evt || bad) begin
          good_n = '0;
        end
      end
      TRACK: begin
        // Tallies saturate rather than roll over so a long run never looks clean.
        if (legal && enable && prev == MAX_Q) begin
          wrap_n = 1'b1;
          if (wraps != '1) wraps_n = wraps + WRAP_W'(1);
        end else if (clr_evt) begin
          rsync_n = 1'b1;
          wraps_n = '0;
        end else if (bad) begin
          err_n   = 1'b1;
          if (err_cnt != '1) err_cnt_n = err_cnt + ERR_W'(1);
          state_n = SEEK;
          good_n  = '0;
        end
      end
      default: state_n = SEEK;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear) begin
      state   <= SEEK;
      prev    <= '0;
      pv      <= 1'b0;
      good    <= '0;
      wrap    <= 1'b0;
      rsync   <= 1'b0;
      wraps   <= '0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      state   <= state_n;
      prev    <= q_in;
      pv      <= 1'b1;
      good    <= good_n;
      wrap    <= wrap_n;
      rsync   <= rsync_n;
      wraps   <= wraps_n;
      err     <= err_n;
      err_cnt <= err_cnt_n;
    end
  end

endmodule

// File: tb/tb_count_checker.sv
// Directed bench for count_checker: lock, wrap, resync, error, hold,
// saturation and mid-run reset, with hand-computed expectations.
module tb_count_checker;

  logic       clock;
  logic       clear;
  logic [3:0] q_in;
  logic       enable;
  logic       locked, wrap, rsync, err;
  logic [7:0] wraps;
  logic [3:0] err_cnt;

  int checkCount = 0;
  int errorCount = 0;

  count_checker #(.WIDTH(4), .WRAP_W(8), .ERR_W(4), .LOCK_N(2)) dut (
    .clock(clock), .clear(clear), .q_in(q_in), .enable(enable),
    .locked(locked), .wrap(wrap), .rsync(rsync), .wraps(wraps),
    .err(err), .err_cnt(err_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one sample, let it be clocked in, then settle past the edge.
  task automatic applyStimulus(input logic [3:0] q, input logic en);
    q_in   = q;
    enable = en;
    @(posedge clock);
    #1;
  endtask

  task automatic runLap(input int start);
    for (int v = start; v <= 15; v++) applyStimulus(4'(v), 1'b1);
    applyStimulus(4'd0, 1'b1);
  endtask

  initial begin
    clear  = 1'b0;
    q_in   = 4'd9;
    enable = 1'b1;
    #2;
    // Reset held with arbitrary inputs.
    applyStimulus(4'd9, 1'b1);
    applyStimulus(4'd3, 1'b0);
    applyStimulus(4'd15, 1'b1);
    checkOutput("rst_locked", 32'(locked), 32'd0);
    checkOutput("rst_wrap", 32'(wrap), 32'd0);
    checkOutput("rst_rsync", 32'(rsync), 32'd0);
    checkOutput("rst_wraps", 32'(wraps), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);

    // Acquire lock: 0 loads, 1 and 2 are the two advancing steps.
    clear = 1'b1;
    applyStimulus(4'd0, 1'b1);
    checkOutput("lock_after0", 32'(locked), 32'd0);
    applyStimulus(4'd1, 1'b1);
    checkOutput("lock_after1", 32'(locked), 32'd0);
    applyStimulus(4'd2, 1'b1);
    checkOutput("lock_after2", 32'(locked), 32'd1);

    // Wrap pulse and tally.
    for (int v = 3; v <= 15; v++) applyStimulus(4'(v), 1'b1);
    checkOutput("wrap_pre", 32'(wrap), 32'd0);
    applyStimulus(4'd0, 1'b1);
    checkOutput("wrap_pulse", 32'(wrap), 32'd1);
    checkOutput("wraps_1", 32'(wraps), 32'd1);
    applyStimulus(4'd1, 1'b1);
    checkOutput("wrap_one_cycle", 32'(wrap), 32'd0);
    runLap(2);
    checkOutput("wraps_2", 32'(wraps), 32'd2);
    runLap(1);
    checkOutput("wraps_3", 32'(wraps), 32'd3);

    // Upstream clear while tracking.
    for (int v = 1; v <= 7; v++) applyStimulus(4'(v), 1'b1);
    applyStimulus(4'd0, 1'b1);
    checkOutput("rsync_pulse", 32'(rsync), 32'd1);
    checkOutput("rsync_wrap", 32'(wrap), 32'd0);
    checkOutput("rsync_wraps", 32'(wraps), 32'd0);
    checkOutput("rsync_locked", 32'(locked), 32'd1);
    checkOutput("rsync_err", 32'(err), 32'd0);
    applyStimulus(4'd1, 1'b1);
    checkOutput("rsync_one_cycle", 32'(rsync), 32'd0);

    // Sequence error 5 -> 7, then relock on 8, 9.
    for (int v = 2; v <= 5; v++) applyStimulus(4'(v), 1'b1);
    applyStimulus(4'd7, 1'b1);
    checkOutput("bad_err", 32'(err), 32'd1);
    checkOutput("bad_err_cnt", 32'(err_cnt), 32'd1);
    checkOutput("bad_locked", 32'(locked), 32'd0);
    applyStimulus(4'd8, 1'b1);
    checkOutput("relock_8", 32'(locked), 32'd0);
    applyStimulus(4'd9, 1'b1);
    checkOutput("relock_9", 32'(locked), 32'd1);

    // Hold with enable low.
    for (int i = 0; i < 10; i++) applyStimulus(4'd9, 1'b0);
    checkOutput("hold_err_cnt", 32'(err_cnt), 32'd1);
    checkOutput("hold_locked", 32'(locked), 32'd1);

    // Max -> 0 with enable low is a clear, not a wrap.
    for (int v = 10; v <= 15; v++) applyStimulus(4'(v), 1'b1);
    applyStimulus(4'd0, 1'b0);
    checkOutput("hold0_rsync", 32'(rsync), 32'd1);
    checkOutput("hold0_wrap", 32'(wrap), 32'd0);

    // Wrap tally saturation.
    for (int i = 0; i < 300; i++) runLap(1);
    checkOutput("wraps_sat", 32'(wraps), 32'd255);
    checkOutput("wrap_at_sat", 32'(wrap), 32'd1);

    // Error tally saturation: each bad step is followed by a relock.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(4'd5, 1'b1);
      applyStimulus(4'd6, 1'b1);
      applyStimulus(4'd7, 1'b1);
    end
    checkOutput("err_cnt_sat", 32'(err_cnt), 32'd15);
    checkOutput("err_sat_locked", 32'(locked), 32'd1);

    // Build WRAPS=5 with ERR set, then reset mid-track.
    applyStimulus(4'd0, 1'b1);
    checkOutput("pre_rst_wraps0", 32'(wraps), 32'd0);
    for (int i = 0; i < 5; i++) runLap(1);
    checkOutput("pre_rst_wraps5", 32'(wraps), 32'd5);
    clear = 1'b0;
    applyStimulus(4'd3, 1'b1);
    checkOutput("mid_rst_locked", 32'(locked), 32'd0);
    checkOutput("mid_rst_wrap", 32'(wrap), 32'd0);
    checkOutput("mid_rst_wraps", 32'(wraps), 32'd0);
    checkOutput("mid_rst_err", 32'(err), 32'd0);
    checkOutput("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    clear = 1'b1;
    applyStimulus(4'd4, 1'b1);
    applyStimulus(4'd5, 1'b1);
    checkOutput("mid_relock_5", 32'(locked), 32'd0);
    applyStimulus(4'd6, 1'b1);
    checkOutput("mid_relock_6", 32'(locked), 32'd1);

    // Upstream stuck in clear.
    applyStimulus(4'd0, 1'b1);
    checkOutput("stuck_rsync1", 32'(rsync), 32'd1);
    applyStimulus(4'd0, 1'b1);
    checkOutput("stuck_rsync2", 32'(rsync), 32'd1);
    applyStimulus(4'd0, 1'b0);
    checkOutput("stuck_hold_rsync", 32'(rsync), 32'd0);
    checkOutput("stuck_hold_err", 32'(err), 32'd0);
    checkOutput("stuck_locked", 32'(locked), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
